// File: rtl/psum_acc_buffer.sv
// psum_acc_buffer: in-place lane-wise signed accumulate buffer with
// hazard forwarding, registered ReLU readout and a clear sweep.
module psum_acc_buffer #(
   parameter int LANES      = 8,
   parameter int PSUM_BW    = 16,
   parameter int DEPTH      = 324,
   parameter int ADDR_WIDTH = 9,
   parameter int SATURATE   = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        acc_valid,
   output logic                        acc_ready,
   input  logic                        acc_mode,
   input  logic [ADDR_WIDTH-1:0]       acc_addr,
   input  logic [LANES*PSUM_BW-1:0]    acc_data,
   input  logic                        rd_en,
   input  logic [ADDR_WIDTH-1:0]       rd_addr,
   input  logic                        rd_relu,
   output logic [LANES*PSUM_BW-1:0]    rd_data,
   output logic                        rd_valid,
   input  logic                        clear_start,
   output logic                        busy,
   output logic                        addr_err
);

   localparam int W = LANES * PSUM_BW;
   localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [PSUM_BW-1:0]    LANE_MAX  = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic [PSUM_BW-1:0]    LANE_MIN  = {1'b1, {(PSUM_BW-1){1'b0}}};

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   (* ram_style = "block" *) logic [W-1:0] mem [DEPTH];

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] clr_addr;

   logic                  acc_fire;
   logic                  rd_fire;
   logic                  acc_in_range;
   logic                  rd_in_range;

   logic [W-1:0]          acc_q;
   logic                  s1_valid;
   logic                  s1_ok;
   logic                  s1_mode;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [W-1:0]          s1_data;
   logic                  s1_fwd;
   logic [W-1:0]          fwd_word;
   logic [W-1:0]          s1_old;
   logic [W-1:0]          s1_result;

   logic                  we;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [W-1:0]          wr_data;

   logic [W-1:0]          rd_raw;
   logic                  rd_zero;
   logic                  rd_relu_q;

   function automatic logic [PSUM_BW-1:0] lane_op(
      input logic [PSUM_BW-1:0] old,
      input logic [PSUM_BW-1:0] d,
      input logic               add
   );
      logic [PSUM_BW:0] sum;
      logic             ovf;
      sum = {old[PSUM_BW-1], old} + {d[PSUM_BW-1], d};
      ovf = sum[PSUM_BW] ^ sum[PSUM_BW-1];
      if (!add)
         lane_op = d;
      else if ((SATURATE != 0) && ovf)
         lane_op = sum[PSUM_BW] ? LANE_MIN : LANE_MAX;
      else
         lane_op = sum[PSUM_BW-1:0];
   endfunction

   assign busy         = (state == ST_CLEAR);
   assign acc_ready    = ~busy;
   assign acc_fire     = acc_valid & ~busy;
   assign rd_fire      = rd_en & ~busy;
   assign acc_in_range = ({1'b0, acc_addr} < DEPTH_X);
   assign rd_in_range  = ({1'b0, rd_addr} < DEPTH_X);

   // Two synchronous read ports into the same array, both read-first.
   always_ff @(posedge clk) begin
      if (acc_fire && acc_in_range)
         acc_q <= mem[acc_addr];
   end

   always_ff @(posedge clk) begin
      if (rd_fire && rd_in_range)
         rd_raw <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_fwd   <= 1'b0;
      end else begin
         s1_valid <= acc_fire;
         s1_fwd   <= acc_fire & s1_valid & (s1_addr == acc_addr);
      end
   end

   always_ff @(posedge clk) begin
      if (acc_fire) begin
         s1_addr <= acc_addr;
         s1_data <= acc_data;
         s1_mode <= acc_mode;
         s1_ok   <= acc_in_range;
      end
      fwd_word <= s1_result;
   end

   // RAM output is one write stale when the previous op hit the same entry.
   assign s1_old = s1_fwd ? fwd_word : acc_q;

   always_comb begin
      s1_result = '0;
      for (int i = 0; i < LANES; i++) begin
         s1_result[i*PSUM_BW +: PSUM_BW] =
            lane_op(s1_old[i*PSUM_BW +: PSUM_BW],
                    s1_data[i*PSUM_BW +: PSUM_BW],
                    s1_mode);
      end
   end

   // A request accepted alongside clear_start is superseded by the sweep.
   always_comb begin
      we      = 1'b0;
      wr_addr = s1_addr;
      wr_data = s1_result;
      if (!reset) begin
         if (busy) begin
            we      = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
         end else if (s1_valid && s1_ok) begin
            we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         clr_addr <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (clear_start) begin
                  state    <= ST_CLEAR;
                  clr_addr <= '0;
               end
            end
            ST_CLEAR: begin
               if (clr_addr == LAST_ADDR)
                  state <= ST_IDLE;
               clr_addr <= clr_addr + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid  <= 1'b0;
         rd_zero   <= 1'b1;
         rd_relu_q <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) begin
            rd_zero   <= ~rd_in_range;
            rd_relu_q <= rd_relu;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         addr_err <= 1'b0;
      else if ((acc_fire && !acc_in_range) || (rd_fire && !rd_in_range))
         addr_err <= 1'b1;
   end

   always_comb begin
      rd_data = '0;
      if (!rd_zero) begin
         for (int i = 0; i < LANES; i++) begin
            if (!(rd_relu_q && rd_raw[i*PSUM_BW + PSUM_BW - 1]))
               rd_data[i*PSUM_BW +: PSUM_BW] = rd_raw[i*PSUM_BW +: PSUM_BW];
         end
      end
   end

endmodule

// File: tb/tb_psum_acc_buffer.sv
// tb_psum_acc_buffer: wrap and saturate instances against a word-level
// reference model, directed corner cases plus randomized traffic.
module tb_psum_acc_buffer;

   localparam int LANES = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 324;
   localparam int AW    = 9;
   localparam int W     = LANES * BW;

   logic          clk = 1'b0;
   logic          reset;
   logic          acc_valid;
   logic          acc_mode;
   logic [AW-1:0] acc_addr;
   logic [W-1:0]  acc_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_relu;
   logic          clear_start;

   logic          acc_ready0, acc_ready1;
   logic [W-1:0]  rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic          busy0, busy1;
   logic          addr_err0, addr_err1;

   always #5 clk = ~clk;

   psum_acc_buffer #(
      .LANES(LANES), .PSUM_BW(BW), .DEPTH(DEPTH),
      .ADDR_WIDTH(AW), .SATURATE(0)
   ) dut0 (
      .clk(clk), .reset(reset),
      .acc_valid(acc_valid), .acc_ready(acc_ready0),
      .acc_mode(acc_mode), .acc_addr(acc_addr), .acc_data(acc_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_relu(rd_relu),
      .rd_data(rd_data0), .rd_valid(rd_valid0),
      .clear_start(clear_start), .busy(busy0), .addr_err(addr_err0)
   );

   psum_acc_buffer #(
      .LANES(LANES), .PSUM_BW(BW), .DEPTH(DEPTH),
      .ADDR_WIDTH(AW), .SATURATE(1)
   ) dut1 (
      .clk(clk), .reset(reset),
      .acc_valid(acc_valid), .acc_ready(acc_ready1),
      .acc_mode(acc_mode), .acc_addr(acc_addr), .acc_data(acc_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_relu(rd_relu),
      .rd_data(rd_data1), .rd_valid(rd_valid1),
      .clear_start(clear_start), .busy(busy1), .addr_err(addr_err1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0]  m0 [DEPTH];
   logic [W-1:0]  m1 [DEPTH];
   bit            e_busy;
   int            sweep_i;
   bit            e_err;
   bit            e_rv;
   logic [W-1:0]  e_rd0, e_rd1;
   bit            pend;
   logic [AW-1:0] p_addr;
   logic [W-1:0]  p_data;
   bit            p_mode;

   function automatic logic [W-1:0] f_acc(input logic [W-1:0] old,
                                          input logic [W-1:0] d,
                                          input bit mode, input bit sat);
      logic [W-1:0] r;
      int a, b, s;
      int hi, lo;
      r  = '0;
      hi = (1 << (BW - 1)) - 1;
      lo = -(1 << (BW - 1));
      for (int i = 0; i < LANES; i++) begin
         a = int'($signed(old[i*BW +: BW]));
         b = int'($signed(d[i*BW +: BW]));
         s = mode ? a + b : b;
         if (sat && s > hi) s = hi;
         if (sat && s < lo) s = lo;
         r[i*BW +: BW] = s[BW-1:0];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] f_relu(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < LANES; i++)
         if (int'($signed(v[i*BW +: BW])) < 0)
            r[i*BW +: BW] = '0;
      return r;
   endfunction

   initial begin
      bit            s_rst, s_av, s_am, s_re, s_rl, s_cs, bb;
      logic [AW-1:0] s_aa, s_ra;
      logic [W-1:0]  s_ad;
      for (int i = 0; i < DEPTH; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      e_busy = 0; sweep_i = 0; e_err = 0; e_rv = 0;
      e_rd0 = '0; e_rd1 = '0; pend = 0;
      forever begin
         @(posedge clk);
         s_rst = reset; s_av = acc_valid; s_am = acc_mode;
         s_aa = acc_addr; s_ad = acc_data; s_re = rd_en;
         s_ra = rd_addr; s_rl = rd_relu; s_cs = clear_start;
         if (s_rst) begin
            e_busy = 0; sweep_i = 0; e_err = 0; e_rv = 0;
            e_rd0 = '0; e_rd1 = '0; pend = 0;
         end else begin
            bb   = e_busy;
            e_rv = 0;
            if (s_re && !bb) begin
               e_rv = 1;
               if (int'(s_ra) < DEPTH) begin
                  e_rd0 = s_rl ? f_relu(m0[s_ra]) : m0[s_ra];
                  e_rd1 = s_rl ? f_relu(m1[s_ra]) : m1[s_ra];
               end else begin
                  e_rd0 = '0;
                  e_rd1 = '0;
                  e_err = 1;
               end
            end
            if (pend) begin
               m0[p_addr] = f_acc(m0[p_addr], p_data, p_mode, 1'b0);
               m1[p_addr] = f_acc(m1[p_addr], p_data, p_mode, 1'b1);
               pend = 0;
            end
            if (bb) begin
               m0[sweep_i] = '0;
               m1[sweep_i] = '0;
               sweep_i++;
               if (sweep_i == DEPTH) e_busy = 0;
            end
            if (s_av && !bb) begin
               if (int'(s_aa) >= DEPTH) e_err = 1;
               else if (!s_cs) begin
                  pend = 1; p_addr = s_aa; p_data = s_ad; p_mode = s_am;
               end
            end
            if (s_cs && !bb) begin
               e_busy  = 1;
               sweep_i = 0;
            end
         end
         #1;
         chk("rd_valid0",  W'(rd_valid0),  W'(e_rv));
         chk("rd_valid1",  W'(rd_valid1),  W'(e_rv));
         chk("rd_data0",   rd_data0,       e_rd0);
         chk("rd_data1",   rd_data1,       e_rd1);
         chk("busy0",      W'(busy0),      W'(e_busy));
         chk("busy1",      W'(busy1),      W'(e_busy));
         chk("acc_ready0", W'(acc_ready0), W'(!e_busy));
         chk("acc_ready1", W'(acc_ready1), W'(!e_busy));
         chk("addr_err0",  W'(addr_err0),  W'(e_err));
         chk("addr_err1",  W'(addr_err1),  W'(e_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input bit av, input bit am, input logic [AW-1:0] aa,
                         input logic [W-1:0] ad, input bit re,
                         input logic [AW-1:0] ra, input bit rl, input bit cs);
      acc_valid = av; acc_mode = am; acc_addr = aa; acc_data = ad;
      rd_en = re; rd_addr = ra; rd_relu = rl; clear_start = cs;
   endtask

   task automatic drive(input bit av, input bit am, input logic [AW-1:0] aa,
                        input logic [W-1:0] ad, input bit re,
                        input logic [AW-1:0] ra, input bit rl, input bit cs);
      @(negedge clk);
      set_in(av, am, aa, ad, re, ra, rl, cs);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, '0, '0, 0, '0, 0, 0);
   endtask

   task automatic acc(input int a, input logic [W-1:0] d, input bit mode);
      drive(1, mode, AW'(a), d, 0, '0, 0, 0);
   endtask

   task automatic rd(input int a, input bit relu, output logic [W-1:0] d0,
                     output logic [W-1:0] d1, output bit v);
      drive(0, 0, '0, '0, 1, AW'(a), relu, 0);
      @(posedge clk);
      #2;
      d0 = rd_data0;
      d1 = rd_data1;
      v  = rd_valid0;
   endtask

   function automatic logic [W-1:0] splat(input logic [BW-1:0] v);
      return {LANES{v}};
   endfunction

   task automatic do_clear(output int cnt);
      drive(0, 0, '0, '0, 0, '0, 0, 1);
      @(negedge clk);
      set_in(0, 0, '0, '0, 0, '0, 0, 0);
      cnt = 0;
      while (busy0 && cnt < DEPTH + 50) begin
         set_in(1, 1, '0, splat(16'h0011), 1, '0, 0, 0);
         cnt++;
         @(negedge clk);
      end
      set_in(0, 0, '0, '0, 0, '0, 0, 0);
   endtask

   function automatic logic [AW-1:0] pick();
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)  return AW'($urandom_range(DEPTH, (1 << AW) - 1));
      if (r < 12) return AW'($urandom_range(0, DEPTH - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      logic [W-1:0] d0, d1, ld, lr;
      bit           v;
      int           cnt;

      reset = 1'b1;
      set_in(0, 0, '0, '0, 0, '0, 0, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy",     W'(busy0),      W'(0));
      chk("reset_ready",    W'(acc_ready0), W'(1));
      chk("reset_rd_valid", W'(rd_valid0),  W'(0));
      chk("reset_rd_data",  rd_data0,       '0);
      chk("reset_addr_err", W'(addr_err0),  W'(0));

      do_clear(cnt);
      chk("clear_cycles_first", W'(cnt), W'(DEPTH));

      acc(5, splat(16'h0003), 0);
      idle(1);
      rd(5, 0, d0, d1, v);
      chk("overwrite_data", d0, splat(16'h0003));
      chk("overwrite_valid", W'(v), W'(1));

      for (int k = 1; k <= 4; k++) acc(7, W'(k), 1);
      idle(1);
      rd(7, 0, d0, d1, v);
      chk("fwd_b2b", d0, W'(10));
      chk("model_fwd_b2b", m0[7], W'(10));
      for (int k = 1; k <= 6; k++) acc((k % 2 == 1) ? 7 : 8, W'(k), 1);
      idle(1);
      rd(7, 0, d0, d1, v);
      chk("fwd_alt_7", d0, W'(19));
      rd(8, 0, d0, d1, v);
      chk("fwd_alt_8", d0, W'(12));

      acc(10, W'(16'h7FFF), 0);
      acc(10, W'(16'h0001), 1);
      idle(1);
      rd(10, 0, d0, d1, v);
      chk("ovf_wrap", d0, W'(16'h8000));
      chk("ovf_sat",  d1, W'(16'h7FFF));
      acc(11, W'(16'h8000), 0);
      acc(11, W'(16'hFFFF), 1);
      idle(1);
      rd(11, 0, d0, d1, v);
      chk("unf_sat",  d1, W'(16'h8000));
      chk("unf_wrap", d0, W'(16'h7FFF));
      chk("model_unf_sat", m1[11], W'(16'h8000));

      ld = {16'hFFFE, 16'h7FFF, 16'h8000, 16'h0003,
            16'hFFFF, 16'h0000, 16'h0007, 16'hFFFB};
      lr = {16'h0000, 16'h7FFF, 16'h0000, 16'h0003,
            16'h0000, 16'h0000, 16'h0007, 16'h0000};
      acc(12, ld, 0);
      idle(1);
      rd(12, 1, d0, d1, v);
      chk("relu_on", d0, lr);
      rd(12, 0, d0, d1, v);
      chk("relu_off", d0, ld);

      acc(0, splat(16'h0055), 0);
      acc(DEPTH - 1, splat(16'h0066), 0);
      idle(2);
      do_clear(cnt);
      chk("clear_cycles", W'(cnt), W'(DEPTH));
      rd(0, 0, d0, d1, v);
      chk("clear_addr0", d0, '0);
      rd(DEPTH - 1, 0, d0, d1, v);
      chk("clear_addr_last", d0, '0);

      acc(0, splat(16'h0042), 0);
      acc(DEPTH - 1, splat(16'h0042), 0);
      idle(2);
      drive(0, 0, '0, '0, 0, '0, 0, 1);
      idle(100);
      @(negedge clk);
      reset = 1'b1;
      set_in(0, 0, '0, '0, 0, '0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", W'(busy0), W'(0));
      rd(DEPTH - 1, 0, d0, d1, v);
      chk("abort_last_kept", d0, splat(16'h0042));
      rd(0, 0, d0, d1, v);
      chk("abort_addr0_cleared", d0, '0);

      acc(400, splat(16'h0009), 0);
      idle(1);
      chk("oor_acc_err", W'(addr_err0), W'(1));
      rd(330, 0, d0, d1, v);
      chk("oor_rd_data", d0, '0);
      chk("oor_rd_valid", W'(v), W'(1));
      idle(5);
      chk("oor_err_sticky", W'(addr_err0), W'(1));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("oor_err_reset", W'(addr_err0), W'(0));

      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 999) == 0);
         set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                pick(), {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), pick(),
                1'($urandom_range(0, 1)), ($urandom_range(0, 699) == 0));
      end
      @(negedge clk);
      reset = 1'b0;
      set_in(0, 0, '0, '0, 0, '0, 0, 0);
      for (int k = 0; k < DEPTH + 50 && busy0; k++) @(negedge clk);
      for (int a = 0; a < DEPTH; a++) drive(0, 0, '0, '0, 1, AW'(a), 0, 0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
